// File: rtl/lvds_link_pkg.sv
// Link-format constants and word layout shared by the LVDS TX framer, RX side and link block.
package lvds_link_pkg;

    localparam logic [31:0] IDLE_WORD = 32'h5252_5252;
    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned SEQ_W     = 7;
    localparam int unsigned SEQ_LSB   = 24;
    localparam int unsigned PAYLOAD_W = 24;

    typedef struct packed {
        logic                 valid;
        logic [SEQ_W-1:0]     seq;
        logic [PAYLOAD_W-1:0] payload;
    } link_word_t;

    function automatic logic [31:0] make_link_word(input logic [SEQ_W-1:0]     seq,
                                                   input logic [PAYLOAD_W-1:0] payload);
        link_word_t w;
        w.valid   = 1'b1;
        w.seq     = seq;
        w.payload = payload;
        return w;
    endfunction

endpackage

// File: rtl/lvds_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with separate occupancy count and read-while-empty flag.
module lvds_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             rd_err_o
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full_o    = (count_q == FullCount);
    assign empty_o   = (count_q == '0);
    assign wr_ok     = wr_en_i & ~full_o;
    assign rd_ok     = rd_en_i & ~empty_o;
    assign rd_err_o  = rd_en_i & empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/lvds_tx_framer.sv
// TX framer: stamps payloads with a valid marker and sequence number, buffers them for the link.
module lvds_tx_framer
    import lvds_link_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 tx_inclock,
    input  logic                 reset_n,
    input  logic [PAYLOAD_W-1:0] usr_data,
    input  logic                 usr_valid,
    output logic                 usr_ready,
    output logic [31:0]          enq_tx,
    output logic                 RDY_enq_tx,
    input  logic                 EN_enq_tx,
    output logic [AW:0]          fifo_count,
    output logic                 pop_err
);

    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             pop_err_q, pop_err_d;
    logic             push;
    logic             full, empty, rd_err;
    logic [31:0]      head_word, push_word;

    assign usr_ready = ~full;
    assign push      = usr_valid & usr_ready;
    assign push_word = make_link_word(seq_q, usr_data);

    lvds_sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clk_i    (tx_inclock),
        .rst_ni   (reset_n),
        .wr_en_i  (push),
        .wr_data_i(push_word),
        .rd_en_i  (EN_enq_tx),
        .rd_data_o(head_word),
        .count_o  (fifo_count),
        .full_o   (full),
        .empty_o  (empty),
        .rd_err_o (rd_err)
    );

    always_comb begin
        seq_d     = seq_q;
        pop_err_d = pop_err_q | rd_err;
        if (push) seq_d = seq_q + SEQ_W'(1);
    end

    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            seq_q     <= '0;
            pop_err_q <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            pop_err_q <= pop_err_d;
        end
    end

    // The stale storage word is masked so an empty buffer always shows the idle pattern.
    assign enq_tx     = empty ? IDLE_WORD : head_word;
    assign RDY_enq_tx = ~empty;
    assign pop_err    = pop_err_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Self-checking bench for lvds_tx_framer: directed vector table plus queue-model random traffic.
module tb_lvds_tx_framer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam logic [31:0] IDLE  = 32'h5252_5252;

    logic          tx_inclock;
    logic          reset_n;
    logic [23:0]   usr_data;
    logic          usr_valid;
    logic          usr_ready;
    logic [31:0]   enq_tx;
    logic          RDY_enq_tx;
    logic          EN_enq_tx;
    logic [AW:0]   fifo_count;
    logic          pop_err;

    lvds_tx_framer #(.DEPTH(DEPTH)) dut (
        .tx_inclock(tx_inclock),
        .reset_n   (reset_n),
        .usr_data  (usr_data),
        .usr_valid (usr_valid),
        .usr_ready (usr_ready),
        .enq_tx    (enq_tx),
        .RDY_enq_tx(RDY_enq_tx),
        .EN_enq_tx (EN_enq_tx),
        .fifo_count(fifo_count),
        .pop_err   (pop_err)
    );

    initial tx_inclock = 1'b0;
    always #5 tx_inclock = ~tx_inclock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of framed words, next sequence number, sticky error.
    logic [31:0] mq[$];
    int          mseq = 0;
    bit          merr = 1'b0;
    int          gap  = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("enq_tx", enq_tx, (mq.size() != 0) ? mq[0] : IDLE);
        chk("RDY_enq_tx", 32'(RDY_enq_tx), 32'(mq.size() != 0));
        chk("usr_ready", 32'(usr_ready), 32'(mq.size() != DEPTH));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("pop_err", 32'(pop_err), 32'(merr));
    endtask

    // One clock: check current outputs against model, drive inputs, advance model and DUT.
    task automatic cyc(input bit v, input logic [23:0] d, input bit en);
        bit do_pop, do_push;
        chk_model();
        usr_valid = v;
        usr_data  = d;
        EN_enq_tx = en;
        do_pop  = en && (mq.size() != 0);
        do_push = v && (mq.size() != DEPTH);
        if (en && mq.size() == 0) merr = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back({1'b1, 7'(mseq), d});
            mseq = (mseq + 1) % 128;
        end
        gap = en ? 1 : gap + 1;
        @(posedge tx_inclock);
        #1;
        usr_valid = 1'b0;
        EN_enq_tx = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        usr_valid = 1'b0;
        EN_enq_tx = 1'b0;
        reset_n   = 1'b0;
        repeat (n) @(posedge tx_inclock);
        #1;
        reset_n = 1'b1;
        mq.delete();
        mseq = 0;
        merr = 1'b0;
        chk("rst_enq_tx", enq_tx, IDLE);
        chk("rst_RDY", 32'(RDY_enq_tx), 32'd0);
        chk("rst_usr_ready", 32'(usr_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_pop_err", 32'(pop_err), 32'd0);
    endtask

    typedef struct {
        bit          v;
        logic [23:0] d;
        bit          en;
        bit          ready;
        bit          rdy;
        logic [31:0] word;
        int          cnt;
        bit          err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Expected outputs are those after the edge that applies the row's inputs.
        tbl[0] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'h5252_5252, 0, 1'b0};
        tbl[1] = '{1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b1, 32'h80AB_CDEF, 1, 1'b0};
        tbl[2] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 32'h5252_5252, 0, 1'b0};
        tbl[3] = '{1'b1, 24'h123456, 1'b0, 1'b1, 1'b1, 32'h8112_3456, 1, 1'b0};
        tbl[4] = '{1'b1, 24'h000001, 1'b0, 1'b1, 1'b1, 32'h8112_3456, 2, 1'b0};
        tbl[5] = '{1'b1, 24'h000002, 1'b1, 1'b1, 1'b1, 32'h8200_0001, 2, 1'b0};
        tbl[6] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 32'h8300_0002, 1, 1'b0};
        tbl[7] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 32'h5252_5252, 0, 1'b0};
        tbl[8] = '{1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 32'h84FF_FFFF, 1, 1'b1};
        tbl[9] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 32'h84FF_FFFF, 1, 1'b1};

        reset_n   = 1'b0;
        usr_valid = 1'b0;
        usr_data  = '0;
        EN_enq_tx = 1'b0;
        #1;
        do_reset(3);

        for (int i = 0; i < 10; i++) begin
            usr_valid = tbl[i].v;
            usr_data  = tbl[i].d;
            EN_enq_tx = tbl[i].en;
            @(posedge tx_inclock);
            #1;
            usr_valid = 1'b0;
            EN_enq_tx = 1'b0;
            chk($sformatf("tbl%0d_word", i), enq_tx, tbl[i].word);
            chk($sformatf("tbl%0d_rdy", i), 32'(RDY_enq_tx), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ready", i), 32'(usr_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_err", i), 32'(pop_err), 32'(tbl[i].err));
        end

        // Fill, refused ninth offer, pop at full, drain.
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 24'(i + 24'h100), 1'b0);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ready", 32'(usr_ready), 32'd0);
        cyc(1'b1, 24'hDEAD00, 1'b0);
        chk("ninth_count", 32'(fifo_count), 32'd8);
        cyc(1'b1, 24'hDEAD01, 1'b1);
        chk("pop_full_count", 32'(fifo_count), 32'd7);
        chk("pop_full_ready", 32'(usr_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            idle(3);
            cyc(1'b0, 24'h0, 1'b1);
        end
        chk("drained_rdy", 32'(RDY_enq_tx), 32'd0);
        idle(1);

        // Push and pop together at count 3.
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 24'($urandom), 1'b0);
        cyc(1'b1, 24'h333333, 1'b1);
        chk("pushpop_count", 32'(fifo_count), 32'd3);
        idle(4);

        // Sequence wrap: 130 words with a pop every fourth cycle, then drain.
        do_reset(1);
        begin
            int pushed = 0;
            int c = 0;
            while (pushed < 130) begin
                if (mq.size() != DEPTH) pushed++;
                cyc(1'b1, 24'($urandom), (c % 4) == 0);
                c++;
            end
            while (mq.size() != 0 && c < 2000) begin
                cyc(1'b0, 24'h0, (c % 4) == 0);
                c++;
            end
            chk("wrap_drained", 32'(fifo_count), 32'd0);
            chk("wrap_seq", 32'(mseq), 32'd2);
        end
        idle(4);

        // Mid-stream reset with 5 words buffered and pop_err set.
        cyc(1'b0, 24'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 24'($urandom), 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd5);
        chk("pre_rst_err", 32'(pop_err), 32'd1);
        do_reset(1);
        cyc(1'b1, 24'h0BEEF0, 1'b0);
        chk("post_rst_word", enq_tx, 32'h800B_EEF0);

        // Random traffic with varying offer density and rare resets.
        gap = 100;
        for (int i = 0; i < 3000; i++) begin
            int dens;
            bit v, en;
            dens = (i / 250) % 4;
            v  = ($urandom_range(0, 3) < dens + 1);
            en = (gap >= 4) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 799) == 0) begin
                do_reset(1);
                gap = 100;
            end else begin
                cyc(v, 24'($urandom), en);
            end
        end
        chk_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
